fft_stage_ctrl: RTL and testbench

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_stage_ctrl_if.sv | 46 ++++
 rtl/fft_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_fft_stage_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_if.sv
// Control bundle between fft_stage_ctrl, its address generator and the data RAM.
// With FFT_STAGE_CTRL_ABORT_EN defined the bundle also carries the abort input.
`ifndef LOG_N
`define LOG_N 4
`endif
`ifndef AGU_MODE_WIDTH
`define AGU_MODE_WIDTH 2
`endif

interface fft_stage_ctrl_if #(
   parameter int LOG_N  = `LOG_N,
   parameter int MODE_W = `AGU_MODE_WIDTH
);
   logic              start;
   logic              ifft;
   logic [LOG_N-1:0]  xOpCount;
   logic              x_we_ram;
`ifdef FFT_STAGE_CTRL_ABORT_EN
   logic              abort;
`endif
   logic              c_agu_start;
   logic              agu_reset;
   logic [MODE_W-1:0] c_mode;
   logic              outputEnable;
   logic              controlIFFT;
   logic [LOG_N-1:0]  stage;
   logic              ram_we;
   logic              busy;
   logic              done;

`ifdef FFT_STAGE_CTRL_ABORT_EN
   modport master (output start, ifft, xOpCount, x_we_ram, abort,
                   input  c_agu_start, agu_reset, c_mode, outputEnable,
                          controlIFFT, stage, ram_we, busy, done);
   modport slave  (input  start, ifft, xOpCount, x_we_ram, abort,
                   output c_agu_start, agu_reset, c_mode, outputEnable,
                          controlIFFT, stage, ram_we, busy, done);
`else
   modport master (output start, ifft, xOpCount, x_we_ram,
                   input  c_agu_start, agu_reset, c_mode, outputEnable,
                          controlIFFT, stage, ram_we, busy, done);
   modport slave  (input  start, ifft, xOpCount, x_we_ram,
                   output c_agu_start, agu_reset, c_mode, outputEnable,
                          controlIFFT, stage, ram_we, busy, done);
`endif
endinterface

// File: rtl/fft_stage_ctrl.sv
// Sequences the LOG_N butterfly stages of one FFT/IFFT pass over the address generator.
// FFT_STAGE_CTRL_ABORT_EN adds an abort input that returns the FSM to IDLE.
`ifndef NO_OF_POINTS
`define NO_OF_POINTS 16
`endif
`ifndef LOG_N
`define LOG_N 4
`endif
`ifndef AGU_MODE_WIDTH
`define AGU_MODE_WIDTH 2
`endif
`ifndef AGU_MODE_OP_RAM
`define AGU_MODE_OP_RAM 0
`endif
`ifndef AGU_MODE_BF_RAM
`define AGU_MODE_BF_RAM 1
`endif

module fft_stage_ctrl #(
   parameter int NO_OF_POINTS = `NO_OF_POINTS,
   parameter int LOG_N        = `LOG_N
) (
   input  logic       controlPulse,
   input  logic       reset_n,
   fft_stage_ctrl_if.slave bus
);
   localparam int               MW         = `AGU_MODE_WIDTH;
   localparam logic [MW-1:0]    MODE_OP    = MW'(`AGU_MODE_OP_RAM);
   localparam logic [MW-1:0]    MODE_BF    = MW'(`AGU_MODE_BF_RAM);
   localparam logic [LOG_N-1:0] LAST_OP    = LOG_N'(NO_OF_POINTS/2 - 1);
   localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);

   typedef enum logic [2:0] {IDLE, ARM, LAUNCH, RUN, DRAIN, FINISH} state_t;

   state_t           state, state_nxt;
   logic [LOG_N-1:0] op_prev;
   logic [LOG_N-1:0] stage_q;
   logic [2:0]       drain_cnt;
   logic             ctl_ifft;
   logic             wrap, last_stage, abort_req;

   // A stage ends when the butterfly counter rolls over from its top value to zero.
   assign wrap       = (state == RUN) && (op_prev == LAST_OP) && (bus.xOpCount == '0);
   assign last_stage = (stage_q == LAST_STAGE);

`ifdef FFT_STAGE_CTRL_ABORT_EN
   assign abort_req = bus.abort && (state inside {ARM, LAUNCH, RUN, DRAIN});
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge controlPulse or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ARM;
         ARM:     state_nxt = LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN:     if (wrap && last_stage) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 3'd0) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_req) state_nxt = IDLE;
   end

   always_ff @(posedge controlPulse or negedge reset_n) begin
      if (!reset_n) begin
         op_prev   <= '0;
         stage_q   <= '0;
         drain_cnt <= 3'd0;
         ctl_ifft  <= 1'b0;
      end else begin
         op_prev <= bus.xOpCount;
         if (state == IDLE && bus.start) begin
            ctl_ifft <= bus.ifft;
            stage_q  <= '0;
         end
         if (wrap && !abort_req) begin
            if (!last_stage) stage_q   <= stage_q + 1'b1;
            else             drain_cnt <= 3'd7;
         end else if (state == DRAIN && drain_cnt != 3'd0) begin
            drain_cnt <= drain_cnt - 3'd1;
         end
      end
   end

   always_comb begin
      bus.agu_reset    = 1'b0;
      bus.c_agu_start  = 1'b0;
      bus.c_mode       = MODE_OP;
      bus.outputEnable = 1'b0;
      bus.busy         = 1'b1;
      bus.done         = 1'b0;
      case (state)
         IDLE: begin
            bus.agu_reset = 1'b1;
            bus.busy      = 1'b0;
         end
         ARM: begin
            bus.agu_reset = 1'b1;
            bus.c_mode    = MODE_BF;
         end
         LAUNCH: begin
            bus.c_agu_start  = 1'b1;
            bus.c_mode       = MODE_BF;
            bus.outputEnable = 1'b1;
         end
         RUN, DRAIN: begin
            bus.c_mode       = MODE_BF;
            bus.outputEnable = 1'b1;
         end
         FINISH: begin
            bus.agu_reset = 1'b1;
            bus.done      = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes only pass while butterflies are live; an abort cycle kills the write.
   assign bus.ram_we      = bus.x_we_ram && (state == RUN || state == DRAIN) && !abort_req;
   assign bus.stage       = stage_q;
   assign bus.controlIFFT = ctl_ifft;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with N=16 and a behavioural address generator.
module tb_fft_stage_ctrl;
   localparam int N  = 16;
   localparam int LN = 4;

   logic controlPulse = 1'b0;
   logic reset_n      = 1'b0;
   logic we_force     = 1'b0;
   int   agu_t        = 0;
   logic agu_run      = 1'b0;
   int   checks       = 0;
   int   errors       = 0;

   fft_stage_ctrl_if #(.LOG_N(LN)) bus();
   fft_stage_ctrl #(.NO_OF_POINTS(N), .LOG_N(LN)) dut (
      .controlPulse(controlPulse), .reset_n(reset_n), .bus(bus));

   always #5 controlPulse = ~controlPulse;

   // AGU model: one butterfly every 8 cycles, counting from the c_agu_start cycle.
   always @(posedge controlPulse) begin
      if (bus.agu_reset) begin
         agu_t   <= 0;
         agu_run <= 1'b0;
      end else if (bus.c_agu_start || agu_run) begin
         agu_run <= 1'b1;
         agu_t   <= agu_t + 1;
      end
   end
   assign bus.xOpCount = LN'((agu_t / 8) % 8);
   assign bus.x_we_ram = we_force | (agu_run && (agu_t % 8) == 7);

   int   m_launch, m_nlaunch, m_nst, m_done, m_ndone;
   int   m_st_t[3];
   int   m_st_v[3];
   logic m_busy_bad, m_ctl_bad, m_busy_after;

   // Drives one start and records event times, k = negedges after start was raised.
   task automatic run_xform(input logic ifft_v, input logic toggle, input logic restart);
      int prev;
      prev = 0;
      m_launch = -1; m_nlaunch = 0; m_nst = 0; m_done = -1; m_ndone = 0;
      m_busy_bad = 1'b0; m_ctl_bad = 1'b0; m_busy_after = 1'bx;
      for (int i = 0; i < 3; i++) begin m_st_t[i] = -1; m_st_v[i] = -1; end
      bus.ifft  = ifft_v;
      bus.start = 1'b1;
      for (int k = 1; k <= 280; k++) begin
         @(negedge controlPulse);
         if (k == 1) begin bus.start = 1'b0; prev = int'(bus.stage); end
         if (toggle && (k == 100 || k == 150)) bus.ifft = ~bus.ifft;
         if (restart && k == 120) bus.start = 1'b1;
         if (restart && k == 121) bus.start = 1'b0;
         if (bus.c_agu_start === 1'b1) begin
            if (m_nlaunch == 0) m_launch = k;
            m_nlaunch++;
         end
         if (k >= 2 && int'(bus.stage) != prev) begin
            if (m_nst < 3) begin m_st_t[m_nst] = k; m_st_v[m_nst] = int'(bus.stage); end
            m_nst++;
            prev = int'(bus.stage);
         end
         if (bus.done === 1'b1) begin
            if (m_ndone == 0) m_done = k;
            m_ndone++;
         end
         if (k <= 267 && bus.busy !== 1'b1) m_busy_bad = 1'b1;
         if (k == 268) m_busy_after = bus.busy;
         if (bus.controlIFFT !== ifft_v) m_ctl_bad = 1'b1;
      end
      bus.ifft = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b1;
      bus.ifft  = 1'b1;
      repeat (3) @(negedge controlPulse);
      checks++; if (bus.agu_reset !== 1'b1) begin errors++; $display("FAIL rst_agu_reset: got %b want 1", bus.agu_reset); end
      checks++; if (bus.c_agu_start !== 1'b0) begin errors++; $display("FAIL rst_c_agu_start: got %b want 0", bus.c_agu_start); end
      checks++; if (bus.c_mode !== 2'd0) begin errors++; $display("FAIL rst_c_mode: got %0d want 0", bus.c_mode); end
      checks++; if (bus.outputEnable !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", bus.outputEnable); end
      checks++; if (bus.controlIFFT !== 1'b0) begin errors++; $display("FAIL rst_ctl_ifft: got %b want 0", bus.controlIFFT); end
      checks++; if (bus.stage !== 4'd0) begin errors++; $display("FAIL rst_stage: got %0d want 0", bus.stage); end
      checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b want 00", {bus.busy, bus.done}); end
      reset_n   = 1'b1;
      bus.start = 1'b0;
      bus.ifft  = 1'b0;
      repeat (3) @(negedge controlPulse);
      checks++; if ({bus.busy, bus.agu_reset, bus.controlIFFT} !== 3'b010) begin
         errors++; $display("FAIL rst_start_discard: got busy/agu_reset/ctl=%b want 010", {bus.busy, bus.agu_reset, bus.controlIFFT}); end
   endtask

   task automatic test_basic();
      run_xform(1'b0, 1'b0, 1'b0);
      checks++; if (m_launch != 2) begin errors++; $display("FAIL basic_launch: got %0d want 2", m_launch); end
      checks++; if (m_nlaunch != 1) begin errors++; $display("FAIL basic_launch_width: got %0d want 1", m_nlaunch); end
      checks++; if (m_nst != 3) begin errors++; $display("FAIL basic_stage_steps: got %0d want 3", m_nst); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (m_st_t[i] != 67 + 64*i || m_st_v[i] != i + 1) begin
            errors++; $display("FAIL basic_stage%0d: got t=%0d v=%0d want t=%0d v=%0d", i+1, m_st_t[i], m_st_v[i], 67+64*i, i+1); end
      end
      checks++; if (m_done != 267) begin errors++; $display("FAIL basic_done_time: got %0d want 267", m_done); end
      checks++; if (m_ndone != 1) begin errors++; $display("FAIL basic_done_width: got %0d want 1", m_ndone); end
      checks++; if (m_busy_bad !== 1'b0 || m_busy_after !== 1'b0) begin
         errors++; $display("FAIL basic_busy: got bad=%b after=%b want 0 0", m_busy_bad, m_busy_after); end
   endtask

   task automatic test_ifft();
      run_xform(1'b1, 1'b1, 1'b0);
      checks++; if (m_ctl_bad !== 1'b0) begin errors++; $display("FAIL ifft_hold: got changed want steady 1"); end
      checks++; if (bus.controlIFFT !== 1'b1) begin errors++; $display("FAIL ifft_after_done: got %b want 1", bus.controlIFFT); end
      checks++; if (m_done != 267) begin errors++; $display("FAIL ifft_done_time: got %0d want 267", m_done); end
   endtask

   task automatic test_back_to_back();
      run_xform(1'b0, 1'b0, 1'b1);
      checks++; if (m_nlaunch != 1) begin errors++; $display("FAIL b2b_launch_count: got %0d want 1", m_nlaunch); end
      checks++; if (m_st_t[0] != 67 || m_st_t[1] != 131 || m_st_t[2] != 195 || m_nst != 3) begin
         errors++; $display("FAIL b2b_stages: got %0d %0d %0d n=%0d want 67 131 195 n=3", m_st_t[0], m_st_t[1], m_st_t[2], m_nst); end
      checks++; if (m_done != 267 || m_ndone != 1) begin
         errors++; $display("FAIL b2b_done: got t=%0d n=%0d want t=267 n=1", m_done, m_ndone); end
   endtask

   task automatic test_ram_we();
      we_force = 1'b1;
      @(negedge controlPulse);
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL we_idle: got %b want 0", bus.ram_we); end
      bus.start = 1'b1;
      for (int k = 1; k <= 268; k++) begin
         @(negedge controlPulse);
         if (k == 1) begin
            bus.start = 1'b0;
            checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL we_arm: got %b want 0", bus.ram_we); end
         end
         if (k == 50) begin
            checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL we_run: got %b want 1", bus.ram_we); end
         end
         if (k == 267) begin
            checks++; if ({bus.done, bus.ram_we} !== 2'b10) begin errors++; $display("FAIL we_finish: got done/we=%b want 10", {bus.done, bus.ram_we}); end
         end
         if (k == 268) begin
            checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL we_idle_after: got %b want 0", bus.ram_we); end
         end
      end
      we_force = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic seen, bad;
      seen = 1'b0; bad = 1'b0;
      bus.ifft  = 1'b1;
      bus.start = 1'b1;
      for (int k = 1; k <= 300 && !seen; k++) begin
         @(negedge controlPulse);
         bus.start = 1'b0;
         if (bus.stage == 4'd2) seen = 1'b1;
      end
      bus.ifft = 1'b0;
      checks++; if (!seen) begin errors++; $display("FAIL mid_reach_stage2: got timeout want stage 2"); end
      reset_n = 1'b0;
      #1;
      checks++; if ({bus.agu_reset, bus.c_agu_start, bus.c_mode, bus.outputEnable, bus.controlIFFT, bus.stage, bus.busy, bus.done} !== 12'b1_0_00_0_0_0000_0_0) begin
         errors++; $display("FAIL mid_reset_outputs: got %b want 100000000000",
            {bus.agu_reset, bus.c_agu_start, bus.c_mode, bus.outputEnable, bus.controlIFFT, bus.stage, bus.busy, bus.done}); end
      @(negedge controlPulse);
      reset_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge controlPulse);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL mid_no_done: got done/busy activity want idle"); end
      run_xform(1'b0, 1'b0, 1'b0);
      checks++; if (m_nst != 3 || m_st_v[2] != 3 || m_done != 267 || m_ndone != 1) begin
         errors++; $display("FAIL mid_restart: got steps=%0d last=%0d done=%0d n=%0d want 3 3 267 1", m_nst, m_st_v[2], m_done, m_ndone); end
   endtask

`ifdef FFT_STAGE_CTRL_ABORT_EN
   task automatic test_abort();
      logic seen, bad;
      seen = 1'b0; bad = 1'b0;
      we_force  = 1'b1;
      bus.start = 1'b1;
      for (int k = 1; k <= 300 && !seen; k++) begin
         @(negedge controlPulse);
         bus.start = 1'b0;
         if (bus.stage == 4'd1) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL abort_reach_stage1: got timeout want stage 1"); end
      bus.abort = 1'b1;
      #1;
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL abort_we_kill: got %b want 0", bus.ram_we); end
      @(negedge controlPulse);
      bus.abort = 1'b0;
      checks++; if ({bus.busy, bus.agu_reset, bus.outputEnable, bus.done} !== 4'b0100) begin
         errors++; $display("FAIL abort_idle: got busy/agu_reset/oe/done=%b want 0100", {bus.busy, bus.agu_reset, bus.outputEnable, bus.done}); end
      for (int k = 0; k < 300; k++) begin
         @(negedge controlPulse);
         if (bus.done !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
      we_force = 1'b0;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0;
      bus.ifft  = 1'b0;
`ifdef FFT_STAGE_CTRL_ABORT_EN
      bus.abort = 1'b0;
`endif
      test_reset();
      test_basic();
      test_ifft();
      test_back_to_back();
      test_ram_we();
      test_reset_mid();
`ifdef FFT_STAGE_CTRL_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
